multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Control-unit FSM for the MultipleCPU multi-cycle datapath.
- Sits between the instruction register and the datapath.
- Decodes the 6-bit opcode, sequences IF/ID/EXE/MEM/WB, and drives every datapath enable and mux select.
- Counts retired instructions; the Sim bench reads this count.

Parameters:
- ST_W, 3, state register width (fixed encoding below).
- CNT_W, 32, retired-instruction counter width.

Ports:
- CLK  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode from IR[31:26].
- zero  in  1  ALU zero flag, valid in EXE.
- PCWre  out  1  PC write enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read enable.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- RegWre  out  1  register file write enable.
- ALUSrcB  out  1  0=ReadData2, 1=extended immediate.
- ExtSel  out  1  1=sign-extend, 0=zero-extend.
- DBDataSrc  out  1  write-back data: 0=ALU result, 1=memory data.
- WrRegDSrc  out  1  0=PC+4 (jal), 1=DB bus.
- RegDst  out  2  00=$31, 01=rt, 10=rd.
- PCSrc  out  2  00=PC+4, 01=PC+4+(imm<<2), 10=rs (jr), 11=jump target.
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- state  out  3  current state, for debug.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Opcodes:
  - add=000000, sub=000001, addiu=000010, slt=100110, andi=010000, ori=010001
  - sw=110000, lw=110001, beq=110100, bne=110101
  - j=111000, jr=111001, jal=111010, halt=111111
  - any other opcode is undefined.
- State encoding: IF=000, ID=001, EXE_AL=110, EXE_BR=101, EXE_LS=010, MEM=011, WB_AL=111, WB_LD=100. HALT reuses 011 with an internal halt flag set.
- Transitions:
  - IF -> ID.
  - ID -> EXE_AL for add/sub/addiu/slt/andi/ori.
  - ID -> EXE_BR for beq/bne.
  - ID -> EXE_LS for lw/sw.
  - ID -> IF for j/jr/jal/undefined.
  - ID -> HALT for halt.
  - EXE_AL -> WB_AL; EXE_BR -> IF; EXE_LS -> MEM.
  - MEM -> WB_LD for lw, MEM -> IF for sw.
  - WB_AL -> IF; WB_LD -> IF.
  - HALT -> HALT until Reset.
- Latency in cycles: ALU 4, branch 3, sw 4, lw 5, j/jr/jal/undefined 2.
- Outputs are combinational from the state register and op (Moore/Mealy mix). All enables not listed for a state are 0.
- IF: IRWre=1, InsMemRW=1.
- ID:
  - j: PCWre=1, PCSrc=11.
  - jr: PCWre=1, PCSrc=10.
  - jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
  - undefined: PCWre=1, PCSrc=00; executes as a NOP.
- EXE_AL/WB_AL:
  - ALUOp per opcode: add/addiu add, sub sub, andi and, ori or, slt slt.
  - ALUSrcB=1 for immediate forms.
  - ExtSel=0 for andi/ori, 1 otherwise.
  - WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=10 for add/sub/slt, 01 otherwise; PCWre=1, PCSrc=00.
- EXE_BR:
  - ALUOp=001, ALUSrcB=0, ExtSel=1, PCWre=1.
  - PCSrc=01 if (beq and zero) or (bne and not zero), else 00.
- EXE_LS and MEM: ALUOp=000, ALUSrcB=1, ExtSel=1.
- MEM:
  - lw: mRD=1.
  - sw: mWR=1, PCWre=1, PCSrc=00.
- WB_LD: RegWre=1, DBDataSrc=1, WrRegDSrc=1, RegDst=01, PCWre=1, PCSrc=00.
- HALT: all enables 0, PC frozen.
- Retired counter: increments by 1 on each rising edge where PCWre=1, and wraps at 2^CNT_W-1 -> 0. Halt is not counted.
- Reset:
  - Asserting Reset (low) at any time, mid-instruction included, immediately forces state=IF, retired=0, halt flag=0.
  - While Reset is low, outputs show the IF row: IRWre=1, InsMemRW=1, all others 0.
  - First fetch happens on the first rising edge after Reset deasserts.
- op is sampled only in ID and later states; changes to op during IF are ignored.

Test Plan:
- Reset low for 2 cycles, then release, op=000000 (add) -> states IF,ID,EXE_AL,WB_AL,IF; RegWre=1 and RegDst=10 only in WB_AL; retired=1 after the 4th edge.
- op=110001 (lw) -> 5-cycle sequence ending in WB_LD; mRD=1 in MEM; DBDataSrc=1 and RegWre=1 in WB_LD; retired increments once.
- op=110100 (beq), zero=1 then zero=0 on two runs -> PCSrc=01 then 00 in EXE_BR; PCWre=1 both times; 3 cycles each.
- op=111010 (jal) -> in ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0; next state IF.
- op=111111 (halt), then toggle op for 10 cycles -> state stuck, PCWre=0, retired constant; Reset low mid-HALT -> state=IF, retired=0.
- Reset low asynchronously during MEM of sw -> mWR drops immediately, no increment.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Control FSM for the MultipleCPU multi-cycle datapath.
// Decodes op, sequences IF/ID/EXE/MEM/WB, drives datapath controls.
//
// Ports:
//   CLK, Reset      clock (rising edge), async active-low reset
//   op, zero        opcode IR[31:26], ALU zero flag (valid in EXE)
//   PCWre..ALUOp    datapath enables and mux selects
//   state           current state (debug), HALT shows as 011
//   retired         count of edges with PCWre=1 (retired instructions)
module multi_cycle_control #(
    parameter int ST_W  = 3,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic             zero,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             mRD,
    output logic             mWR,
    output logic             RegWre,
    output logic             ALUSrcB,
    output logic             ExtSel,
    output logic             DBDataSrc,
    output logic             WrRegDSrc,
    output logic [1:0]       RegDst,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic [ST_W-1:0]  state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_AL = 3'b110,
        S_EXE_BR = 3'b101,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_AL  = 3'b111,
        S_WB_LD  = 3'b100
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_ANDI  = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010001;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t           state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       is_al, is_br, is_ls, is_halt;
    logic       is_imm, is_logic, is_rtype;
    logic [2:0] al_op;

    // Opcode classification
    always_comb begin
        is_al    = 1'b0;
        is_br    = 1'b0;
        is_ls    = 1'b0;
        is_halt  = 1'b0;
        is_imm   = 1'b0;
        is_logic = 1'b0;
        is_rtype = 1'b0;
        al_op    = 3'b000;
        case (op)
            OP_ADD:   begin is_al = 1'b1; is_rtype = 1'b1; al_op = 3'b000; end
            OP_SUB:   begin is_al = 1'b1; is_rtype = 1'b1; al_op = 3'b001; end
            OP_SLT:   begin is_al = 1'b1; is_rtype = 1'b1; al_op = 3'b100; end
            OP_ADDIU: begin is_al = 1'b1; is_imm = 1'b1; al_op = 3'b000; end
            OP_ANDI:  begin
                is_al = 1'b1; is_imm = 1'b1; is_logic = 1'b1; al_op = 3'b010;
            end
            OP_ORI:   begin
                is_al = 1'b1; is_imm = 1'b1; is_logic = 1'b1; al_op = 3'b011;
            end
            OP_BEQ, OP_BNE: is_br = 1'b1;
            OP_LW, OP_SW:   is_ls = 1'b1;
            OP_HALT:        is_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IF;
            halt_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            halt_q    <= halt_d;
            retired_q <= retired_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    if (is_al)        state_d = S_EXE_AL;
                    else if (is_br)   state_d = S_EXE_BR;
                    else if (is_ls)   state_d = S_EXE_LS;
                    else if (is_halt) begin
                        // HALT shares the MEM encoding, told apart by halt_q
                        state_d = S_MEM;
                        halt_d  = 1'b1;
                    end else          state_d = S_IF;
                end
                S_EXE_AL: state_d = S_WB_AL;
                S_EXE_BR: state_d = S_IF;
                S_EXE_LS: state_d = S_MEM;
                S_MEM:    state_d = (op == OP_LW) ? S_WB_LD : S_IF;
                S_WB_AL:  state_d = S_IF;
                S_WB_LD:  state_d = S_IF;
                default:  state_d = S_IF;
            endcase
        end
    end

    // Outputs
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        RegWre    = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        ALUOp     = 3'b000;
        if (!halt_q) begin
            case (state_q)
                S_IF: begin
                    IRWre    = 1'b1;
                    InsMemRW = 1'b1;
                end
                S_ID: begin
                    if (op == OP_J) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                    end else if (op == OP_JR) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end else if (op == OP_JAL) begin
                        PCWre  = 1'b1;
                        PCSrc  = 2'b11;
                        RegWre = 1'b1;
                    end else if (!(is_al || is_br || is_ls || is_halt)) begin
                        // undefined opcode retires as a NOP
                        PCWre = 1'b1;
                    end
                end
                S_EXE_AL, S_WB_AL: begin
                    ALUOp   = al_op;
                    ALUSrcB = is_imm;
                    ExtSel  = !is_logic;
                    if (state_q == S_WB_AL) begin
                        RegWre    = 1'b1;
                        WrRegDSrc = 1'b1;
                        RegDst    = is_rtype ? 2'b10 : 2'b01;
                        PCWre     = 1'b1;
                    end
                end
                S_EXE_BR: begin
                    ALUOp  = 3'b001;
                    ExtSel = 1'b1;
                    PCWre  = 1'b1;
                    if ((op == OP_BEQ && zero) || (op == OP_BNE && !zero))
                        PCSrc = 2'b01;
                end
                S_EXE_LS, S_MEM: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    if (state_q == S_MEM) begin
                        if (op == OP_LW) begin
                            mRD = 1'b1;
                        end else begin
                            mWR   = 1'b1;
                            PCWre = 1'b1;
                        end
                    end
                end
                S_WB_LD: begin
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = 2'b01;
                    PCWre     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign retired_d = PCWre ? retired_q + CNT_W'(1) : retired_q;
    assign state     = ST_W'(state_q);
    assign retired   = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed testbench for multi_cycle_control.
// One task per scenario, inline checks, single summary line.
module tb_multi_cycle_control;

    logic        CLK, Reset, zero;
    logic [5:0]  op;
    logic        PCWre, IRWre, InsMemRW, mRD, mWR, RegWre;
    logic        ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
    logic [1:0]  RegDst, PCSrc;
    logic [2:0]  ALUOp, state;
    logic [31:0] retired;

    int pass_cnt = 0;
    int total_cnt = 0;

    multi_cycle_control #(.ST_W(3), .CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .mRD(mRD), .mWR(mWR), .RegWre(RegWre), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc),
        .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp),
        .state(state), .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 1'b0; op = 6'b000000; zero = 1'b0;
        @(posedge CLK); @(posedge CLK); @(negedge CLK);
        total_cnt++;
        if (state !== 3'b000) $display("FAIL rst_state got %b exp 000", state);
        else pass_cnt++;
        total_cnt++;
        if ({IRWre, InsMemRW, PCWre, RegWre, mRD, mWR} !== 6'b110000)
            $display("FAIL rst_outs got %b exp 110000",
                     {IRWre, InsMemRW, PCWre, RegWre, mRD, mWR});
        else pass_cnt++;
        total_cnt++;
        if (retired !== 32'd0) $display("FAIL rst_ret got %0d exp 0", retired);
        else pass_cnt++;
        Reset = 1'b1;
    endtask

    task automatic test_add();
        op = 6'b000000;
        step();
        total_cnt++;
        if (state !== 3'b001 || RegWre !== 1'b0)
            $display("FAIL add_id got st=%b rw=%b exp 001/0", state, RegWre);
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b110 || RegWre !== 1'b0 || ALUOp !== 3'b000)
            $display("FAIL add_exe got st=%b rw=%b alu=%b exp 110/0/000",
                     state, RegWre, ALUOp);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({state, RegWre, RegDst, PCWre, WrRegDSrc} !== 8'b111_1_10_1_1)
            $display("FAIL add_wb got %b exp 11111011",
                     {state, RegWre, RegDst, PCWre, WrRegDSrc});
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b000 || retired !== 32'd1)
            $display("FAIL add_done got st=%b ret=%0d exp 000/1", state, retired);
        else pass_cnt++;
    endtask

    task automatic test_lw();
        op = 6'b110001;
        step(); step();
        total_cnt++;
        if (state !== 3'b010 || ALUSrcB !== 1'b1 || ExtSel !== 1'b1)
            $display("FAIL lw_exe got st=%b src=%b ext=%b exp 010/1/1",
                     state, ALUSrcB, ExtSel);
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b011 || mRD !== 1'b1 || PCWre !== 1'b0 || mWR !== 1'b0)
            $display("FAIL lw_mem got st=%b rd=%b pc=%b wr=%b exp 011/1/0/0",
                     state, mRD, PCWre, mWR);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({state, DBDataSrc, RegWre, RegDst, PCWre} !== 8'b100_1_1_01_1)
            $display("FAIL lw_wb got %b exp 10011011",
                     {state, DBDataSrc, RegWre, RegDst, PCWre});
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b000 || retired !== 32'd2)
            $display("FAIL lw_done got st=%b ret=%0d exp 000/2", state, retired);
        else pass_cnt++;
    endtask

    task automatic test_beq(input logic z, input logic [1:0] exp_src,
                            input logic [31:0] exp_ret);
        op = 6'b110100; zero = z;
        step(); step();
        total_cnt++;
        if ({state, PCWre, PCSrc, ALUOp} !== {3'b101, 1'b1, exp_src, 3'b001})
            $display("FAIL beq_z%0d got %b exp %b", z,
                     {state, PCWre, PCSrc, ALUOp},
                     {3'b101, 1'b1, exp_src, 3'b001});
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b000 || retired !== exp_ret)
            $display("FAIL beq_done got st=%b ret=%0d exp 000/%0d",
                     state, retired, exp_ret);
        else pass_cnt++;
        zero = 1'b0;
    endtask

    task automatic test_jal();
        op = 6'b111010;
        step();
        total_cnt++;
        if ({state, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc}
            !== {3'b001, 1'b1, 2'b11, 1'b1, 2'b00, 1'b0})
            $display("FAIL jal_id got %b exp 0011111000",
                     {state, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc});
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b000 || retired !== 32'd5)
            $display("FAIL jal_done got st=%b ret=%0d exp 000/5", state, retired);
        else pass_cnt++;
    endtask

    task automatic test_ori();
        op = 6'b010001;
        step(); step();
        total_cnt++;
        if ({ALUOp, ALUSrcB, ExtSel} !== 5'b011_1_0)
            $display("FAIL ori_exe got %b exp 01110", {ALUOp, ALUSrcB, ExtSel});
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b111 || RegDst !== 2'b01 || RegWre !== 1'b1)
            $display("FAIL ori_wb got st=%b dst=%b rw=%b exp 111/01/1",
                     state, RegDst, RegWre);
        else pass_cnt++;
        step();
    endtask

    task automatic test_undef();
        op = 6'b001111;
        step();
        total_cnt++;
        if ({state, PCWre, PCSrc, RegWre} !== 7'b001_1_00_0)
            $display("FAIL undef_id got %b exp 0011000",
                     {state, PCWre, PCSrc, RegWre});
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b000 || retired !== 32'd7)
            $display("FAIL undef_done got st=%b ret=%0d exp 000/7",
                     state, retired);
        else pass_cnt++;
    endtask

    task automatic test_sw();
        op = 6'b110000;
        step(); step(); step();
        total_cnt++;
        if ({state, mWR, mRD, PCWre, PCSrc} !== 8'b011_1_0_1_00)
            $display("FAIL sw_mem got %b exp 01110100",
                     {state, mWR, mRD, PCWre, PCSrc});
        else pass_cnt++;
        step();
        total_cnt++;
        if (state !== 3'b000 || retired !== 32'd8)
            $display("FAIL sw_done got st=%b ret=%0d exp 000/8", state, retired);
        else pass_cnt++;
    endtask

    task automatic test_sw_reset();
        op = 6'b110000;
        step(); step(); step();
        #2 Reset = 1'b0;
        #1;
        total_cnt++;
        if (mWR !== 1'b0 || state !== 3'b000 || retired !== 32'd0 || IRWre !== 1'b1)
            $display("FAIL swrst_async got wr=%b st=%b ret=%0d ir=%b exp 0/000/0/1",
                     mWR, state, retired, IRWre);
        else pass_cnt++;
        step();
        total_cnt++;
        if (retired !== 32'd0 || state !== 3'b000)
            $display("FAIL swrst_hold got ret=%0d st=%b exp 0/000", retired, state);
        else pass_cnt++;
        Reset = 1'b1;
        op = 6'b000000;
        step();
        total_cnt++;
        if (state !== 3'b001) $display("FAIL swrst_fetch got %b exp 001", state);
        else pass_cnt++;
        step(); step(); step();
    endtask

    task automatic test_halt();
        int bad;
        logic [5:0] ops [4];
        ops[0] = 6'b000000; ops[1] = 6'b110001;
        ops[2] = 6'b111000; ops[3] = 6'b110100;
        op = 6'b111111;
        step();
        total_cnt++;
        if (state !== 3'b001 || PCWre !== 1'b0)
            $display("FAIL halt_id got st=%b pc=%b exp 001/0", state, PCWre);
        else pass_cnt++;
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            op = ops[i % 4];
            zero = i[0];
            #1;
            if (state !== 3'b011 || PCWre !== 1'b0 || retired !== 32'd1 ||
                IRWre !== 1'b0 || mRD !== 1'b0 || mWR !== 1'b0) bad++;
            step();
        end
        total_cnt++;
        if (bad != 0 || state !== 3'b011 || retired !== 32'd1)
            $display("FAIL halt_stuck got bad=%0d st=%b ret=%0d exp 0/011/1",
                     bad, state, retired);
        else pass_cnt++;
        #2 Reset = 1'b0;
        #1;
        total_cnt++;
        if (state !== 3'b000 || retired !== 32'd0 || IRWre !== 1'b1)
            $display("FAIL halt_rst got st=%b ret=%0d ir=%b exp 000/0/1",
                     state, retired, IRWre);
        else pass_cnt++;
        step();
        Reset = 1'b1;
        op = 6'b111000;
        step();
        total_cnt++;
        if (state !== 3'b001 || PCWre !== 1'b1 || PCSrc !== 2'b11)
            $display("FAIL halt_cleared got st=%b pc=%b src=%b exp 001/1/11",
                     state, PCWre, PCSrc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_beq(1'b1, 2'b01, 32'd3);
        test_beq(1'b0, 2'b00, 32'd4);
        test_jal();
        test_ori();
        test_undef();
        test_sw();
        test_sw_reset();
        test_halt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
